// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the CPU memory stage (master)
// and the memory-side responder (slave).
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory port. Accepts one request at
// a time, waits a fixed latency on a 4-bit down-counter, performs the access
// on the edge that enters RESP and holds the response until consumed.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// BUSY  | request latched, cnt counting down to the access edge
// RESP  | resp_valid high, rdata/error held until resp_ready
module data_mem_responder #(
   parameter int MEM_DEPTH = 1024,
   parameter int LATENCY   = 4
) (
   input logic           clk,
   input logic           reset,
   data_mem_responder_if.slave bus
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   // Two-state storage: not cleared by reset, starts at zero in simulation.
   bit   [31:0] mem [MEM_DEPTH];

   logic             acc_error;
   logic [IDX_W-1:0] mem_idx;
   logic             access_now;
   logic             mem_we;

   // Index overflow beyond the array is flagged, never wrapped.
   assign acc_error  = (lat_addr[1:0] != 2'b00) ||
                       ({2'b00, lat_addr[31:2]} >= 32'(MEM_DEPTH));
   assign mem_idx    = lat_addr[IDX_W+1:2];
   assign access_now = (state == BUSY) && (cnt == 4'd0);
   assign mem_we     = access_now && lat_write && !acc_error && !reset;

   assign bus.req_ready = (state == IDLE);

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         lat_write      <= 1'b0;
         lat_addr       <= 32'd0;
         lat_wdata      <= 32'd0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= 32'd0;
         bus.resp_error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_write <= bus.req_write;
                  lat_addr  <= bus.req_addr;
                  lat_wdata <= bus.req_wdata;
                  cnt       <= 4'(LATENCY - 1);
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_error <= acc_error;
                  bus.resp_rdata <= (acc_error || lat_write) ? 32'd0 : mem[mem_idx];
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  bus.resp_valid <= 1'b0;
                  bus.resp_rdata <= 32'd0;
                  bus.resp_error <= 1'b0;
               end
            end
            default: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_rdata <= 32'd0;
               bus.resp_error <= 1'b0;
            end
         endcase
      end
   end

   // Store commit on the access edge; gated off while reset is held.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= lat_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: two instances (LATENCY 4 and 1)
// sharing clock and reset, expected responses queued at acceptance.
module tb_data_mem_responder;

   localparam int LAT_A = 4;
   localparam int LAT_B = 1;
   localparam int DEPTH = 1024;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   data_mem_responder_if bus_a ();
   data_mem_responder_if bus_b ();

   data_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   data_mem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   int          checks = 0;
   int          errors = 0;
   logic [32:0] sb_q [$];
   logic [31:0] mdl [int];

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(int sel, bit v, bit w, logic [31:0] a, logic [31:0] d, bit rr);
      if (sel == 0) begin
         bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a;
         bus_a.req_wdata = d; bus_a.resp_ready = rr;
      end else begin
         bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a;
         bus_b.req_wdata = d; bus_b.resp_ready = rr;
      end
   endtask

   function automatic logic get_rv(int sel);
      return (sel == 0) ? bus_a.resp_valid : bus_b.resp_valid;
   endfunction

   function automatic logic get_rdy(int sel);
      return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
   endfunction

   function automatic logic [31:0] get_rdata(int sel);
      return (sel == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
   endfunction

   function automatic logic get_err(int sel);
      return (sel == 0) ? bus_a.resp_error : bus_b.resp_error;
   endfunction

   // Reference memory: returns {error, rdata} and applies stores.
   function automatic logic [32:0] model_access(int sel, bit wr, logic [31:0] a, logic [31:0] d);
      int key;
      if (a[1:0] != 2'b00 || a[31:2] >= 30'(DEPTH)) return {1'b1, 32'd0};
      key = sel * 2048 + int'(a[11:2]);
      if (wr) begin
         mdl[key] = d;
         return {1'b0, 32'd0};
      end
      return {1'b0, mdl.exists(key) ? mdl[key] : 32'd0};
   endfunction

   task automatic transact(int sel, bit wr, logic [31:0] a, logic [31:0] d, int hold, bit wiggle);
      int          lat;
      int          edges;
      logic [32:0] exp;
      lat = (sel == 0) ? LAT_A : LAT_B;
      @(negedge clk);
      drive(sel, 1'b1, wr, a, d, hold == 0);
      check("req_ready_idle", 64'(get_rdy(sel)), 64'd1);
      @(posedge clk);
      sb_q.push_back(model_access(sel, wr, a, d));
      #1;
      check("req_ready_busy", 64'(get_rdy(sel)), 64'd0);
      drive(sel, 1'b0, wr, a, d, hold == 0);
      edges = 0;
      do begin
         if (wiggle)
            drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, hold == 0);
         @(posedge clk);
         edges++;
         #1;
      end while (!get_rv(sel) && edges < 40);
      check("resp_latency", 64'(edges), 64'(lat));
      exp = sb_q.pop_front();
      if (!get_rv(sel)) begin
         drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
         return;
      end
      check("resp_rdata", 64'(get_rdata(sel)), 64'(exp[31:0]));
      check("resp_error", 64'(get_err(sel)), 64'(exp[32]));
      for (int i = 0; i < hold; i++) begin
         drive(sel, (i % 2) == 0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
         @(posedge clk);
         #1;
         check("hold_valid", 64'(get_rv(sel)), 64'd1);
         check("hold_rdata", 64'(get_rdata(sel)), 64'(exp[31:0]));
         check("hold_error", 64'(get_err(sel)), 64'(exp[32]));
         check("hold_req_ready", 64'(get_rdy(sel)), 64'd0);
      end
      drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      @(posedge clk);
      #1;
      check("resp_released", 64'(get_rv(sel)), 64'd0);
      check("back_to_idle", 64'(get_rdy(sel)), 64'd1);
      check("rdata_cleared", 64'(get_rdata(sel)), 64'd0);
      check("error_cleared", 64'(get_err(sel)), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

      // Reset state
      #2 reset = 1'b1;
      #3;
      check("rst_req_ready_a", 64'(bus_a.req_ready), 64'd1);
      check("rst_resp_valid_a", 64'(bus_a.resp_valid), 64'd0);
      check("rst_rdata_a", 64'(bus_a.resp_rdata), 64'd0);
      check("rst_error_a", 64'(bus_a.resp_error), 64'd0);
      check("rst_req_ready_b", 64'(bus_b.req_ready), 64'd1);
      check("rst_resp_valid_b", 64'(bus_b.resp_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Store then load, then backpressure with ignored req_valid pulses
      transact(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0);
      transact(0, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
      transact(0, 1'b0, 32'h0000_0010, 32'h0, 6, 1'b0);

      // Errors: misaligned load, out-of-range store must not wrap onto index 0
      transact(0, 1'b0, 32'h0000_0013, 32'h0, 0, 1'b0);
      transact(0, 1'b1, 32'h0000_0000, 32'hA5A5_5A5A, 0, 1'b0);
      transact(0, 1'b1, 32'h0000_1000, 32'h1111_2222, 0, 1'b0);
      transact(0, 1'b0, 32'h0000_0000, 32'h0, 0, 1'b0);
      transact(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 0, 1'b0);

      // Inputs wiggled while BUSY are ignored
      transact(0, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 0, 1'b1);
      transact(0, 1'b0, 32'h0000_0024, 32'h0, 2, 1'b1);

      // Reset in BUSY aborts the pending store
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("busy_rst_req_ready", 64'(bus_a.req_ready), 64'd1);
      check("busy_rst_resp_valid", 64'(bus_a.resp_valid), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      transact(0, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);

      // Reset in RESP discards the response but keeps the committed store
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h0000_0030, 32'h55AA_33CC, 1'b0);
      @(posedge clk);
      void'(model_access(0, 1'b1, 32'h0000_0030, 32'h55AA_33CC));
      #1 drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      edges = 0;
      while (!bus_a.resp_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         #1;
      end
      check("resp_rst_latency", 64'(edges), 64'(LAT_A));
      reset = 1'b1;
      #1;
      check("resp_rst_resp_valid", 64'(bus_a.resp_valid), 64'd0);
      check("resp_rst_req_ready", 64'(bus_a.req_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      transact(0, 1'b0, 32'h0000_0030, 32'h0, 0, 1'b0);

      // LATENCY=1 instance: single transactions, then back-to-back loads
      transact(1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 0, 1'b0);
      transact(1, 1'b0, 32'h0000_0008, 32'h0, 0, 1'b0);
      transact(1, 1'b0, 32'h0000_0009, 32'h0, 1, 1'b0);
      drive(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         check("b2b_req_ready", 64'(bus_b.req_ready), 64'((i % 3) == 0));
         if ((i % 3) == 2) begin
            check("b2b_resp_valid", 64'(bus_b.resp_valid), 64'd1);
            check("b2b_rdata", 64'(bus_b.resp_rdata), 64'h0BAD_F00D);
         end
         @(posedge clk);
         #1;
      end
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("b2b_final_idle", 64'(bus_b.req_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
